// File: rtl/wbu_pkg.sv
// Shared register-file geometry and the write-back request record for the WBU.
package wbu_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic      vld;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/wbu_fifo.sv
// Load-result buffer: in-order FIFO with per-entry live bits that an ALU write can kill by address.
module wbu_fifo
  import wbu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  reg_addr_t              push_rd,
  input  reg_data_t              push_data,
  input  logic                   pop,
  input  logic                   kill_vld,
  input  reg_addr_t              kill_rd,
  output logic                   full,
  output logic                   empty,
  output reg_addr_t              head_rd,
  output reg_data_t              head_data,
  output logic                   head_live,
  output reg_addr_t [DEPTH-1:0]  entry_rd,
  output logic      [DEPTH-1:0]  entry_live
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] live;
  reg_addr_t        rd_mem   [DEPTH];
  reg_data_t        data_mem [DEPTH];

  // Kill is applied first so an entry pushed in the same cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_vld && (kill_rd != REG_ZERO) && (rd_mem[i] == kill_rd)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (push) begin
        live[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    entry_rd = '0;
    for (int i = 0; i < DEPTH; i++) entry_rd[i] = rd_mem[i];
  end

  assign entry_live = live;
  assign full       = (cnt == CW'(DEPTH));
  assign empty      = (cnt == '0);
  assign head_rd    = rd_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign head_live  = live[rd_ptr];
endmodule

// File: rtl/wbu.sv
// Write-back unit: arbitrates ALU and load results into a single register-file write port,
// with ALU priority, load bypass, a load buffer and WAW kill of stale buffered loads.
module wbu
  import wbu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wbu_alu_vld_i,
  input  reg_addr_t wbu_alu_rd_addr_i,
  input  reg_data_t wbu_alu_rd_data_i,
  input  logic      wbu_lsu_vld_i,
  input  reg_addr_t wbu_lsu_rd_addr_i,
  input  reg_data_t wbu_lsu_rd_data_i,
  output logic      wbu_lsu_rdy_o,
  output reg_addr_t wbu_rd_addr_o,
  output reg_data_t wbu_rd_data_o,
  output logic      wbu_rd_wr_en_o,
  input  reg_addr_t wbu_rs1_addr_i,
  input  reg_addr_t wbu_rs2_addr_i,
  output logic      wbu_rs1_busy_o,
  output logic      wbu_rs2_busy_o,
  output logic      wbu_idle_o
);
  logic                  full;
  logic                  empty;
  reg_addr_t             head_rd;
  reg_data_t             head_data;
  logic                  head_live;
  reg_addr_t [DEPTH-1:0] entry_rd;
  logic      [DEPTH-1:0] entry_live;

  logic    lsu_acc;
  logic    bypass;
  logic    push;
  logic    pop;
  wb_req_t out_q;

  assign wbu_lsu_rdy_o = !full && !rst;
  assign lsu_acc       = wbu_lsu_vld_i && wbu_lsu_rdy_o;
  assign bypass        = lsu_acc && empty && !wbu_alu_vld_i;
  assign push          = lsu_acc && !bypass;
  assign pop           = !wbu_alu_vld_i && !empty;

  wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (wbu_lsu_rd_addr_i),
    .push_data  (wbu_lsu_rd_data_i),
    .pop        (pop),
    .kill_vld   (wbu_alu_vld_i),
    .kill_rd    (wbu_alu_rd_addr_i),
    .full       (full),
    .empty      (empty),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .head_live  (head_live),
    .entry_rd   (entry_rd),
    .entry_live (entry_live)
  );

  // A killed head still drains in order but lands with vld low so nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (wbu_alu_vld_i) begin
      out_q <= '{vld: 1'b1, addr: wbu_alu_rd_addr_i, data: wbu_alu_rd_data_i};
    end else if (pop) begin
      out_q <= '{vld: head_live, addr: head_rd, data: head_data};
    end else if (bypass) begin
      out_q <= '{vld: 1'b1, addr: wbu_lsu_rd_addr_i, data: wbu_lsu_rd_data_i};
    end else begin
      out_q.vld <= 1'b0;
    end
  end

  assign wbu_rd_addr_o  = out_q.addr;
  assign wbu_rd_data_o  = out_q.data;
  assign wbu_rd_wr_en_o = out_q.vld && (out_q.addr != REG_ZERO);
  assign wbu_idle_o     = rst || (empty && !out_q.vld);

  // The output register is deliberately excluded; the register-file bypass covers it.
  always_comb begin
    wbu_rs1_busy_o = 1'b0;
    wbu_rs2_busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i] && (entry_rd[i] == wbu_rs1_addr_i)) wbu_rs1_busy_o = 1'b1;
      if (entry_live[i] && (entry_rd[i] == wbu_rs2_addr_i)) wbu_rs2_busy_o = 1'b1;
    end
    if (rst || (wbu_rs1_addr_i == REG_ZERO)) wbu_rs1_busy_o = 1'b0;
    if (rst || (wbu_rs2_addr_i == REG_ZERO)) wbu_rs2_busy_o = 1'b0;
  end
endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed vector table with hand-derived ready/busy values, then random traffic,
// all writes checked against a queue-based reference model through an expected-write scoreboard.
module tb_wbu;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_vld;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_rdy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wr_en;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        idle;

  always #5 clk = ~clk;

  wbu #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .wbu_alu_vld_i     (alu_vld),
    .wbu_alu_rd_addr_i (alu_rd),
    .wbu_alu_rd_data_i (alu_data),
    .wbu_lsu_vld_i     (lsu_vld),
    .wbu_lsu_rd_addr_i (lsu_rd),
    .wbu_lsu_rd_data_i (lsu_data),
    .wbu_lsu_rdy_o     (lsu_rdy),
    .wbu_rd_addr_o     (rd_addr),
    .wbu_rd_data_o     (rd_data),
    .wbu_rd_wr_en_o    (rd_wr_en),
    .wbu_rs1_addr_i    (rs1),
    .wbu_rs2_addr_i    (rs2),
    .wbu_rs1_busy_o    (rs1_busy),
    .wbu_rs2_busy_o    (rs2_busy),
    .wbu_idle_o        (idle)
  );

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adat;
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  rs1;
    bit          erdy;
    bit          ebusy1;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          live;
  } ment_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ld_t;

  vec_t  vecs[26];
  ment_t mq[$];
  ld_t   lq[$];
  ld_t   exp_q[$];
  bit    m_out_vld = 1'b0;
  bit    prev_rst  = 1'b0;
  bit    started   = 1'b0;
  int    nerr      = 0;
  int    nchk      = 0;

  function automatic vec_t mk(bit r, bit av, logic [4:0] ard, logic [31:0] adat, bit lv,
                              logic [4:0] lrd, logic [31:0] ldat, logic [4:0] s1, bit erdy, bit eb1);
    vec_t v;
    v = '{rst: r, av: av, ard: ard, adat: adat, lv: lv, lrd: lrd, ldat: ldat,
          rs1: s1, erdy: erdy, ebusy1: eb1};
    return v;
  endfunction

  function automatic bit mbusy(logic [4:0] rs);
    bit b = 1'b0;
    if (rs == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == rs) b = 1'b1;
    return b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit av, logic [4:0] ard, logic [31:0] adat,
                      logic [4:0] r1, logic [4:0] r2);
    bit    m_rdy;
    bit    acc;
    bit    was_empty;
    bit    ov;
    logic [4:0]  oa;
    logic [31:0] od;
    ld_t   w;
    ment_t e;
    @(negedge clk);
    rst      = r;
    alu_vld  = av;
    alu_rd   = ard;
    alu_data = adat;
    lsu_vld  = (lq.size() > 0);
    lsu_rd   = (lq.size() > 0) ? lq[0].rd : 5'd0;
    lsu_data = (lq.size() > 0) ? lq[0].d : 32'd0;
    rs1      = r1;
    rs2      = r2;
    #1;
    m_rdy = !r && (mq.size() < DEPTH);
    chk("lsu_rdy", lsu_rdy, m_rdy);
    chk("rs1_busy", rs1_busy, !r && mbusy(r1));
    chk("rs2_busy", rs2_busy, !r && mbusy(r2));
    chk("idle", idle, r || (mq.size() == 0 && !m_out_vld));
    if (started) begin
      chk("wr_en", rd_wr_en, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        if (rd_wr_en) begin
          chk("wr_addr", rd_addr, w.rd);
          chk("wr_data", rd_data, w.d);
        end
      end
    end
    if (prev_rst) begin
      chk("rst_addr", rd_addr, 32'd0);
      chk("rst_data", rd_data, 32'd0);
    end
    started = 1'b1;
    if (r) begin
      mq.delete();
      lq.delete();
      exp_q.delete();
      m_out_vld = 1'b0;
      prev_rst  = 1'b1;
    end else begin
      acc       = lsu_vld && m_rdy;
      was_empty = (mq.size() == 0);
      ov = 1'b0; oa = 5'd0; od = 32'd0;
      if (av) begin
        ov = 1'b1; oa = ard; od = adat;
      end else if (!was_empty) begin
        e = mq.pop_front();
        ov = e.live; oa = e.rd; od = e.d;
      end else if (acc) begin
        ov = 1'b1; oa = lq[0].rd; od = lq[0].d;
      end
      if (av && ard != 5'd0) foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      if (acc) begin
        if (!(was_empty && !av)) mq.push_back('{rd: lq[0].rd, d: lq[0].d, live: 1'b1});
        void'(lq.pop_front());
      end
      m_out_vld = ov;
      if (ov && oa != 5'd0) exp_q.push_back('{rd: oa, d: od});
      prev_rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_vld = 1'b0; lsu_rd = '0; lsu_data = '0; rs1 = '0; rs2 = '0;

    vecs[0]  = mk(1, 0, 0,  0,          0, 0,  0,           3,  0, 0);
    vecs[1]  = mk(0, 1, 5,  32'h1234,   0, 0,  0,           5,  1, 0);
    vecs[2]  = mk(0, 0, 0,  0,          0, 0,  0,           5,  1, 0);
    vecs[3]  = mk(0, 0, 0,  0,          0, 0,  0,           5,  1, 0);
    vecs[4]  = mk(0, 0, 0,  0,          1, 7,  32'hA5A5A5A5, 7, 1, 0);
    vecs[5]  = mk(0, 0, 0,  0,          0, 0,  0,           7,  1, 0);
    vecs[6]  = mk(0, 1, 10, 32'h1,      1, 3,  32'h33,      3,  1, 0);
    vecs[7]  = mk(0, 1, 11, 32'h2,      1, 4,  32'h44,      3,  1, 1);
    vecs[8]  = mk(0, 1, 12, 32'h3,      1, 9,  32'h99,      3,  0, 1);
    vecs[9]  = mk(0, 1, 13, 32'h4,      0, 0,  0,           4,  0, 1);
    vecs[10] = mk(0, 0, 0,  0,          0, 0,  0,           3,  0, 1);
    vecs[11] = mk(0, 0, 0,  0,          0, 0,  0,           3,  1, 0);
    vecs[12] = mk(0, 0, 0,  0,          0, 0,  0,           9,  1, 1);
    vecs[13] = mk(0, 0, 0,  0,          0, 0,  0,           9,  1, 0);
    vecs[14] = mk(0, 1, 1,  32'hAA,     1, 8,  32'hDEAD,    8,  1, 0);
    vecs[15] = mk(0, 1, 8,  32'h11,     0, 0,  0,           8,  1, 1);
    vecs[16] = mk(0, 0, 0,  0,          0, 0,  0,           8,  1, 0);
    vecs[17] = mk(0, 0, 0,  0,          0, 0,  0,           8,  1, 0);
    vecs[18] = mk(0, 1, 0,  32'h55,     1, 0,  32'h66,      0,  1, 0);
    vecs[19] = mk(0, 0, 0,  0,          0, 0,  0,           0,  1, 0);
    vecs[20] = mk(0, 0, 0,  0,          0, 0,  0,           0,  1, 0);
    vecs[21] = mk(0, 1, 1,  32'h1,      1, 20, 32'h2020,    20, 1, 0);
    vecs[22] = mk(0, 1, 2,  32'h2,      1, 21, 32'h2121,    20, 1, 1);
    vecs[23] = mk(1, 0, 0,  0,          0, 0,  0,           20, 0, 0);
    vecs[24] = mk(0, 0, 0,  0,          0, 0,  0,           20, 1, 0);
    vecs[25] = mk(0, 0, 0,  0,          0, 0,  0,           20, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].lv) lq.push_back('{rd: vecs[i].lrd, d: vecs[i].ldat});
      step(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].rs1, vecs[i].ard);
      chk($sformatf("vec%0d_rdy", i), lsu_rdy, vecs[i].erdy);
      chk($sformatf("vec%0d_busy1", i), rs1_busy, vecs[i].ebusy1);
    end

    for (int n = 0; n < 400; n++) begin
      if (lq.size() < 2 && $urandom_range(0, 1) == 1)
        lq.push_back('{rd: 5'($urandom_range(0, 7)), d: $urandom});
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("drain_exp_q", exp_q.size(), 32'd0);
    chk("drain_idle", idle, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
